// File: rtl/int_pkg.sv
// Shared constants and types for the sample FIFO and the interrupt controller.
package int_pkg;

    localparam int unsigned FIFO_DW    = 24;
    localparam int unsigned FIFO_DEPTH = 64;

    typedef enum logic {
        OV_DROP      = 1'b0,
        OV_OVERWRITE = 1'b1
    } fifo_ov_mode_e;

    localparam int unsigned INT_FIFO_UPOV   = 1;
    localparam int unsigned INT_FIFO_DOWNOV = 2;
    localparam int unsigned INT_FIFO_WL     = 3;

endpackage

// File: rtl/fifo_dpram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// The read register holds its value when re is low, so it doubles as rd_data.
module fifo_dpram #(
    parameter int unsigned DW    = 24,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_32k,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_32k) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read-before-write: a same-address write and read return the old word.
    always_ff @(posedge clk_32k) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sample_fifo_ctrl.sv
// Sample FIFO controller in the 32 kHz domain: pointers, occupancy, status and
// interrupt source flags around a dual-port RAM.
module sample_fifo_ctrl
    import int_pkg::*;
#(
    parameter int unsigned DW    = FIFO_DW,
    parameter int unsigned DEPTH = FIFO_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_32k,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_vld,
    input  logic [AW:0]   rg_fifo_waterline,
    input  logic          rg_fifo_ov_mode,
    input  logic          rg_fifo_flush,
    output logic [AW:0]   fifo_cnt,
    output logic          fifo_full,
    output logic          fifo_empty,
    output logic          fifo_upov_flag,
    output logic          fifo_downov_flag,
    output logic          fifo_waterline_flag
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          rd_vld_q, rd_vld_d;
    logic          upov_q, upov_d;
    logic          downov_q, downov_d;
    logic          wl_q, wl_d;

    logic overwrite;
    logic rd_acc;
    logic wr_hit_full;
    logic wr_store;
    logic rd_adv;
    logic cnt_inc;
    logic mem_we;
    logic mem_re;

    assign overwrite = (fifo_ov_mode_e'(rg_fifo_ov_mode) == OV_OVERWRITE);

    always_comb begin
        rd_acc      = rd_en && !empty_q;
        // A full FIFO is never empty, so rd_en here always means an accepted read.
        wr_hit_full = wr_en && full_q && !rd_en;
        wr_store    = wr_en && (!full_q || rd_en || overwrite);
        rd_adv      = rd_acc || (wr_hit_full && overwrite);
        cnt_inc     = wr_store && (!full_q || rd_acc);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        rd_vld_d = 1'b0;
        upov_d   = 1'b0;
        downov_d = 1'b0;
        mem_we   = 1'b0;
        mem_re   = 1'b0;

        if (rg_fifo_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            mem_we   = wr_store && rst_n;
            mem_re   = rd_acc && rst_n;
            rd_vld_d = rd_acc;
            upov_d   = wr_hit_full;
            downov_d = rd_en && empty_q;
            if (wr_store) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (rd_adv) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            cnt_d = cnt_q + (AW+1)'(cnt_inc) - (AW+1)'(rd_acc);
        end

        full_d  = (cnt_d == (AW+1)'(DEPTH));
        empty_d = (cnt_d == '0);
        // Occupancy never exceeds DEPTH, so a larger threshold never fires.
        wl_d    = (rg_fifo_waterline != '0) && (cnt_d >= rg_fifo_waterline);
    end

    always_ff @(posedge clk_32k) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            rd_vld_q <= 1'b0;
            upov_q   <= 1'b0;
            downov_q <= 1'b0;
            wl_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            rd_vld_q <= rd_vld_d;
            upov_q   <= upov_d;
            downov_q <= downov_d;
            wl_q     <= wl_d;
        end
    end

    fifo_dpram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo_dpram (
        .clk_32k (clk_32k),
        .rst_n   (rst_n),
        .we      (mem_we),
        .waddr   (wr_ptr_q),
        .wdata   (wr_data),
        .re      (mem_re),
        .raddr   (rd_ptr_q),
        .rdata   (rd_data)
    );

    assign rd_vld              = rd_vld_q;
    assign fifo_cnt            = cnt_q;
    assign fifo_full           = full_q;
    assign fifo_empty          = empty_q;
    assign fifo_upov_flag      = upov_q;
    assign fifo_downov_flag    = downov_q;
    assign fifo_waterline_flag = wl_q;

endmodule
